uart_pkt_ctrl: RTL and testbench

Parametrised packet controller between the UART RX/TX interfaces and the ALU datapath. It receives a packet of one instruction byte plus two operands of `OPND_BYTES` bytes each, MSB first, and steers each byte into instruction/operand storage. It then enables the ALU, waits for the result, and streams `RES_BYTES` result bytes back through the TX interface, MSB first. An optional inter-byte receive timeout aborts stalled packets.

---
 rtl/uart_pkt_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_pkt_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/uart_pkt_ctrl.sv
// Packet controller between UART RX/TX and the ALU: loads INS + two operands MSB-first,
// runs the ALU, streams result bytes back. Optional RX timeout under UART_PKT_RX_TIMEOUT_EN.
module uart_pkt_ctrl #(
    parameter int OPND_BYTES  = 2,
    parameter int RES_BYTES   = 2,
    parameter int TIMEOUT_CYC = 100000,
    localparam int OW = (OPND_BYTES > 1) ? $clog2(OPND_BYTES) : 1,
    localparam int RW = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          Rx_DV_in,
    input  logic          Tx_Done_in,
    input  logic          c_valid_in,
    output logic          En_out,
    output logic          Load_INS_en_out,
    output logic          Load_a_en_out,
    output logic          Load_b_en_out,
    output logic [OW-1:0] Load_idx_out,
    output logic          Tx_DV_out,
    output logic [RW-1:0] Tx_sel_out,
    output logic          Busy_out,
    output logic          Err_out
);
    localparam int P  = 1 + 2 * OPND_BYTES;
    localparam int CW = $clog2(P);
    localparam logic [CW-1:0] OB_C   = CW'(OPND_BYTES);
    localparam logic [CW-1:0] LAST_C = CW'(P - 1);
    localparam logic [RW-1:0] SLAST  = RW'(RES_BYTES - 1);

    if (OPND_BYTES < 1 || OPND_BYTES > 8 || RES_BYTES < 1 || RES_BYTES > 8 || TIMEOUT_CYC < 2)
    begin : g_bad_param
        $error("uart_pkt_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {IDLE, LOAD, EXE, SEND_REQ, SEND_WAIT} state_t;

    state_t        state, nstate;
    logic [CW-1:0] cnt, ncnt;
    logic [RW-1:0] sidx, nsidx;
    logic          ins, lda, ldb;
    logic [OW-1:0] idx;
    logic          abort;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
            sidx  <= '0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            sidx  <= nsidx;
        end
    end

`ifdef UART_PKT_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] tcnt;
    logic          err;

    assign abort = (state == LOAD) && !Rx_DV_in && (tcnt == TLAST);

    // Counter only runs while sitting in LOAD with no byte arriving.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tcnt <= '0;
            err  <= 1'b0;
        end else begin
            err <= abort;
            if (state != LOAD || Rx_DV_in || abort) tcnt <= '0;
            else                                     tcnt <= tcnt + TW'(1);
        end
    end
    assign Err_out = err;
`else
    assign abort   = 1'b0;
    assign Err_out = 1'b0;
`endif

    always_comb begin
        nstate = state;
        ncnt   = cnt;
        nsidx  = sidx;
        ins    = 1'b0;
        lda    = 1'b0;
        ldb    = 1'b0;
        idx    = '0;
        case (state)
            IDLE: if (Rx_DV_in) begin
                ins    = 1'b1;
                ncnt   = CW'(1);
                nstate = LOAD;
            end
            LOAD: begin
                if (Rx_DV_in) begin
                    if (cnt <= OB_C) begin
                        lda = 1'b1;
                        idx = OW'(cnt - CW'(1));
                    end else begin
                        ldb = 1'b1;
                        idx = OW'(cnt - CW'(1) - OB_C);
                    end
                    if (cnt == LAST_C) begin
                        nstate = EXE;
                        ncnt   = '0;
                    end else begin
                        ncnt = cnt + CW'(1);
                    end
                end else if (abort) begin
                    nstate = IDLE;
                    ncnt   = '0;
                end
            end
            EXE: if (c_valid_in) begin
                nsidx  = '0;
                nstate = SEND_REQ;
            end
            SEND_REQ: nstate = SEND_WAIT;
            SEND_WAIT: if (Tx_Done_in) begin
                if (sidx == SLAST) begin
                    nstate = IDLE;
                end else begin
                    nsidx  = sidx + RW'(1);
                    nstate = SEND_REQ;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    // Strobes are combinational from Rx_DV_in; gate them so reset holds every output low.
    assign Load_INS_en_out = ins & RST;
    assign Load_a_en_out   = lda & RST;
    assign Load_b_en_out   = ldb & RST;
    assign Load_idx_out    = idx & {OW{RST}};
    assign En_out          = (state == EXE);
    assign Tx_DV_out       = (state == SEND_REQ);
    assign Tx_sel_out      = sidx;
    assign Busy_out        = (state != IDLE);
endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Directed bench for uart_pkt_ctrl: default, 4/3-byte and timeout-configured instances.
module tb_uart_pkt_ctrl;
    logic clk, RST;
    logic rx [3];
    logic done [3];
    logic cv [3];
    logic [14:0] obs [3];
    int vectors = 0;
    int miscompares = 0;

    logic       en0, ins0, a0, b0, tx0, bz0, er0;
    logic [0:0] idx0, sel0;
    logic       en1, ins1, a1, b1, tx1, bz1, er1;
    logic [1:0] idx1, sel1;
    logic       en2, ins2, a2, b2, tx2, bz2, er2;
    logic [0:0] idx2, sel2;

    uart_pkt_ctrl u0 (
        .CLK(clk), .RST(RST), .Rx_DV_in(rx[0]), .Tx_Done_in(done[0]), .c_valid_in(cv[0]),
        .En_out(en0), .Load_INS_en_out(ins0), .Load_a_en_out(a0), .Load_b_en_out(b0),
        .Load_idx_out(idx0), .Tx_DV_out(tx0), .Tx_sel_out(sel0), .Busy_out(bz0), .Err_out(er0));

    uart_pkt_ctrl #(.OPND_BYTES(4), .RES_BYTES(3)) u1 (
        .CLK(clk), .RST(RST), .Rx_DV_in(rx[1]), .Tx_Done_in(done[1]), .c_valid_in(cv[1]),
        .En_out(en1), .Load_INS_en_out(ins1), .Load_a_en_out(a1), .Load_b_en_out(b1),
        .Load_idx_out(idx1), .Tx_DV_out(tx1), .Tx_sel_out(sel1), .Busy_out(bz1), .Err_out(er1));

    uart_pkt_ctrl #(.TIMEOUT_CYC(16)) u2 (
        .CLK(clk), .RST(RST), .Rx_DV_in(rx[2]), .Tx_Done_in(done[2]), .c_valid_in(cv[2]),
        .En_out(en2), .Load_INS_en_out(ins2), .Load_a_en_out(a2), .Load_b_en_out(b2),
        .Load_idx_out(idx2), .Tx_DV_out(tx2), .Tx_sel_out(sel2), .Busy_out(bz2), .Err_out(er2));

    // Observation word: {busy, en, ins, a, b, idx[3:0], txdv, sel[3:0], err}
    assign obs[0] = {bz0, en0, ins0, a0, b0, 3'b0, idx0, tx0, 3'b0, sel0, er0};
    assign obs[1] = {bz1, en1, ins1, a1, b1, 2'b0, idx1, tx1, 2'b0, sel1, er1};
    assign obs[2] = {bz2, en2, ins2, a2, b2, 3'b0, idx2, tx2, 3'b0, sel2, er2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] ex(int bz, int en, int ins, int a, int b, int idx,
                                       int tx, int sel, int er);
        return {bz[0], en[0], ins[0], a[0], b[0], idx[3:0], tx[0], sel[3:0], er[0]};
    endfunction

    task automatic chk(input string tag, input int k, input logic [14:0] expv);
        vectors++;
        assert (obs[k] === expv)
        else begin
            miscompares++;
            $error("FAIL %s inst%0d observed %b expected %b", tag, k, obs[k], expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rx[k] = 1'b0; done[k] = 1'b0; cv[k] = 1'b0;
        end
        tick;
        rx[0] = 1'b1; #1;
        chk("reset_outputs", 0, ex(0,0,0,0,0,0,0,0,0));
        chk("reset_outputs", 1, ex(0,0,0,0,0,0,0,0,0));
        chk("reset_outputs", 2, ex(0,0,0,0,0,0,0,0,0));
        rx[0] = 1'b0;
        tick; RST = 1'b1;
        tick;

        // Default instance: 0x11 0xAB 0xCD 0x12 0x34 with gaps
        rx[0] = 1'b1; #1; chk("ins_strobe", 0, ex(0,0,1,0,0,0,0,0,0));
        tick; rx[0] = 1'b0; #1; chk("load_gap", 0, ex(1,0,0,0,0,0,0,0,0));
        tick; rx[0] = 1'b1; #1; chk("a_idx0", 0, ex(1,0,0,1,0,0,0,0,0));
        tick; rx[0] = 1'b0;
        tick; rx[0] = 1'b1; #1; chk("a_idx1", 0, ex(1,0,0,1,0,1,0,0,0));
        tick; #1; chk("b_idx0", 0, ex(1,0,0,0,1,0,0,0,0));
        tick; rx[0] = 1'b0;
        tick; rx[0] = 1'b1; #1; chk("b_idx1", 0, ex(1,0,0,0,1,1,0,0,0));
        tick; #1; chk("exe_en_rx_dropped", 0, ex(1,1,0,0,0,0,0,0,0));
        tick; rx[0] = 1'b0; cv[0] = 1'b1; #1; chk("exe_cvalid", 0, ex(1,1,0,0,0,0,0,0,0));
        tick; cv[0] = 1'b0; done[0] = 1'b1; #1; chk("req_sel0", 0, ex(1,0,0,0,0,0,1,0,0));
        tick; done[0] = 1'b0; rx[0] = 1'b1; #1; chk("wait_done_in_req_ign", 0, ex(1,0,0,0,0,0,0,0,0));
        tick; rx[0] = 1'b0; #1; chk("wait_no_extra_tx", 0, ex(1,0,0,0,0,0,0,0,0));
        tick; done[0] = 1'b1; #1; chk("wait0_done", 0, ex(1,0,0,0,0,0,0,0,0));
        tick; done[0] = 1'b0; #1; chk("req_sel1", 0, ex(1,0,0,0,0,0,1,1,0));
        tick; done[0] = 1'b1; #1; chk("wait1_done", 0, ex(1,0,0,0,0,0,0,1,0));
        tick; done[0] = 1'b0; rx[0] = 1'b1; #1; chk("idle_accept_ins", 0, ex(0,0,1,0,0,0,0,1,0));
        tick; #1; chk("pkt2_a0", 0, ex(1,0,0,1,0,0,0,1,0));
        tick; #1; chk("pkt2_a1", 0, ex(1,0,0,1,0,1,0,1,0));
        tick; rx[0] = 1'b0; RST = 1'b0; #1; chk("mid_pkt_reset", 0, ex(0,0,0,0,0,0,0,0,0));
        tick; RST = 1'b1;
        tick; rx[0] = 1'b1; #1; chk("post_reset_ins", 0, ex(0,0,1,0,0,0,0,0,0));
        tick; #1; chk("post_reset_a0", 0, ex(1,0,0,1,0,0,0,0,0));
        tick; rx[0] = 1'b0;

        // OPND_BYTES=4, RES_BYTES=3: 9-byte packet back to back
        for (int i = 0; i < 9; i++) begin
            tick; rx[1] = 1'b1; #1;
            if (i == 0)     chk("w4_ins", 1, ex(0,0,1,0,0,0,0,0,0));
            else if (i < 5) chk("w4_a", 1, ex(1,0,0,1,0,i-1,0,0,0));
            else            chk("w4_b", 1, ex(1,0,0,0,1,i-5,0,0,0));
        end
        tick; rx[1] = 1'b0; cv[1] = 1'b1; #1; chk("w4_exe", 1, ex(1,1,0,0,0,0,0,0,0));
        tick; cv[1] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1; chk("w4_req", 1, ex(1,0,0,0,0,0,1,s,0));
            tick; done[1] = 1'b1; #1; chk("w4_wait", 1, ex(1,0,0,0,0,0,0,s,0));
            tick; done[1] = 1'b0;
        end
        #1; chk("w4_idle", 1, ex(0,0,0,0,0,0,0,2,0));

        // Stall after two bytes
        tick; rx[2] = 1'b1; #1; chk("to_ins", 2, ex(0,0,1,0,0,0,0,0,0));
        tick; #1; chk("to_a0", 2, ex(1,0,0,1,0,0,0,0,0));
        tick; rx[2] = 1'b0;
`ifdef UART_PKT_RX_TIMEOUT_EN
        for (int j = 0; j < 18; j++) begin
            if (j > 0) tick;
            #1;
            if (j == 16)      chk("to_err_pulse", 2, ex(0,0,0,0,0,0,0,0,1));
            else if (j == 17) chk("to_err_once", 2, ex(0,0,0,0,0,0,0,0,0));
            else              chk("to_waiting", 2, ex(1,0,0,0,0,0,0,0,0));
        end
        rx[2] = 1'b1; #1; chk("to_next_is_ins", 2, ex(0,0,1,0,0,0,0,0,0));
        tick; #1; chk("to_next_a0", 2, ex(1,0,0,1,0,0,0,0,0));
        tick; rx[2] = 1'b0;
`else
        for (int j = 0; j < 40; j++) begin
            tick; #1; chk("no_timeout_wait", 2, ex(1,0,0,0,0,0,0,0,0));
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
